// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic redirect_trap;
    logic mem_timeout;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_FREEZE = '0;

  localparam hz_ctrl_t CTRL_RUN = '{
    pc_en:         1'b1,
    if_id_en:      1'b1,
    if_id_flush:   1'b0,
    id_ex_en:      1'b1,
    id_ex_flush:   1'b0,
    ex_mem_en:     1'b1,
    redirect_trap: 1'b0,
    mem_timeout:   1'b0
  };

  // Normal advance, but both front-end latches capture a nop.
  function automatic hz_ctrl_t ctrl_squash();
    hz_ctrl_t r;
    r = CTRL_RUN;
    r.if_id_flush = 1'b1;
    r.id_ex_flush = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);

  logic [4:0]       rs1_ID;
  logic [4:0]       rs2_ID;
  logic             rs1_used;
  logic             rs2_used;
  logic [4:0]       rd_EX;
  logic             RegWrite_EX;
  logic             mem_r_EX;
  logic             branch_taken;
  logic             trap_EX;
  logic             dmem_req;
  logic             dmem_ack;

  logic             PC_EN;
  logic             IF_ID_EN;
  logic             IF_ID_flush;
  logic             ID_EX_EN;
  logic             ID_EX_flush;
  logic             EX_MEM_EN;
  logic             redirect_trap;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output rs1_ID, rs2_ID, rs1_used, rs2_used, rd_EX, RegWrite_EX, mem_r_EX,
           branch_taken, trap_EX, dmem_req, dmem_ack,
    input  PC_EN, IF_ID_EN, IF_ID_flush, ID_EX_EN, ID_EX_flush, EX_MEM_EN,
           redirect_trap, mem_timeout, stall_cycles
  );

  modport slave (
    input  rs1_ID, rs2_ID, rs1_used, rs2_used, rd_EX, RegWrite_EX, mem_r_EX,
           branch_taken, trap_EX, dmem_req, dmem_ack,
    output PC_EN, IF_ID_EN, IF_ID_flush, ID_EX_EN, ID_EX_flush, EX_MEM_EN,
           redirect_trap, mem_timeout, stall_cycles
  );

endinterface

// File: rtl/hazard_ctrl_load_use.sv
// Combinational load-use detector: a load in EX writes a register the ID instruction reads.
module load_use_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs1_ID,
  input  logic [4:0] rs2_ID,
  input  logic       rs1_used,
  input  logic       rs2_used,
  input  logic [4:0] rd_EX,
  input  logic       RegWrite_EX,
  input  logic       mem_r_EX,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = rs1_used & (rs1_ID == rd_EX);
  assign rs2_hit  = rs2_used & (rs2_ID == rd_EX);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = mem_r_EX & RegWrite_EX & (rd_EX != REG_X0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles, memory freezes, branch squashes,
// trap/mret drains, and a saturating count of PC-stalled cycles.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int TRAP_DRAIN  = 2,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [2:0]        DRAIN_INIT = 3'(TRAP_DRAIN - 1);

  hz_state_e         state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [2:0]        drain_q, drain_d;
  logic [CNT_W-1:0]  stall_q;
  logic              load_use;
  logic              freeze;
  hz_ctrl_t          ctrl;
  hz_ctrl_t          ctrl_out;

  load_use_detect u_load_use (
    .rs1_ID      (hz.rs1_ID),
    .rs2_ID      (hz.rs2_ID),
    .rs1_used    (hz.rs1_used),
    .rs2_used    (hz.rs2_used),
    .rd_EX       (hz.rd_EX),
    .RegWrite_EX (hz.RegWrite_EX),
    .mem_r_EX    (hz.mem_r_EX),
    .load_use    (load_use)
  );

  assign freeze = hz.dmem_req & ~hz.dmem_ack;

  // A pending data access outranks everything; otherwise the current state picks the event.
  always_comb begin
    ctrl    = CTRL_RUN;
    state_d = state_q;
    wait_d  = '0;
    drain_d = drain_q;
    if (freeze) begin
      ctrl    = CTRL_FREEZE;
      state_d = ST_MEM_WAIT;
      drain_d = '0;
      if (wait_q == WAIT_LAST) begin
        ctrl.mem_timeout = 1'b1;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_MEM_WAIT: begin
          state_d = ST_RUN;
        end
        ST_DRAIN: begin
          ctrl = ctrl_squash();
          if (drain_q <= 3'd1) begin
            state_d = ST_RUN;
            drain_d = '0;
          end else begin
            drain_d = drain_q - 1'b1;
          end
        end
        default: begin
          if (hz.trap_EX) begin
            ctrl               = ctrl_squash();
            ctrl.redirect_trap = 1'b1;
            if (TRAP_DRAIN > 1) begin
              state_d = ST_DRAIN;
              drain_d = DRAIN_INIT;
            end
          end else if (hz.branch_taken) begin
            ctrl = ctrl_squash();
          end else if (load_use) begin
            ctrl.pc_en       = 1'b0;
            ctrl.if_id_en    = 1'b0;
            ctrl.id_ex_flush = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      drain_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      drain_q <= drain_d;
      if (!ctrl.pc_en && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  // Reset forces every control output low without waiting for a clock edge.
  assign ctrl_out = rst ? ctrl : CTRL_FREEZE;

  assign hz.PC_EN         = ctrl_out.pc_en;
  assign hz.IF_ID_EN      = ctrl_out.if_id_en;
  assign hz.IF_ID_flush   = ctrl_out.if_id_flush;
  assign hz.ID_EX_EN      = ctrl_out.id_ex_en;
  assign hz.ID_EX_flush   = ctrl_out.id_ex_flush;
  assign hz.EX_MEM_EN     = ctrl_out.ex_mem_en;
  assign hz.redirect_trap = ctrl_out.redirect_trap;
  assign hz.mem_timeout   = ctrl_out.mem_timeout;
  assign hz.stall_cycles  = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed corner cases then randomized traffic
// against a cycle-level reference model.
module tb_hazard_ctrl;

  localparam int TRAP_DRAIN  = 2;
  localparam int MEM_TIMEOUT = 3;
  localparam int CNT_W       = 8;
  localparam int STALL_MAX   = (1 << CNT_W) - 1;

  typedef struct {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1u;
    logic       rs2u;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       br;
    logic       trap;
    logic       req;
    logic       ack;
  } stim_t;

  typedef struct packed {
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_flush;
    logic             ex_mem_en;
    logic             redirect_trap;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz();

  hazard_ctrl #(
    .TRAP_DRAIN  (TRAP_DRAIN),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  always #5 clk = ~clk;

  obs_t sbq[$];
  int   nChecks = 0;
  int   nBad    = 0;
  int   stepNo  = 0;

  // Reference model: consecutive wait cycles, flush cycles still owed after a trap,
  // whether the previous cycle was frozen, and total stalled cycles.
  int   mWait   = 0;
  int   mDrain  = 0;
  bit   mFrozen = 0;
  int   mStall  = 0;

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b1; s.rs1 = '0; s.rs2 = '0; s.rs1u = 1'b0; s.rs2u = 1'b0;
    s.rd = '0; s.rw = 1'b0; s.mr = 1'b0; s.br = 1'b0; s.trap = 1'b0;
    s.req = 1'b0; s.ack = 1'b0;
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s);
    obs_t e;
    bit   loadUse;
    @(posedge clk);
    #1;
    rst             = s.rst;
    hz.rs1_ID       = s.rs1;
    hz.rs2_ID       = s.rs2;
    hz.rs1_used     = s.rs1u;
    hz.rs2_used     = s.rs2u;
    hz.rd_EX        = s.rd;
    hz.RegWrite_EX  = s.rw;
    hz.mem_r_EX     = s.mr;
    hz.branch_taken = s.br;
    hz.trap_EX      = s.trap;
    hz.dmem_req     = s.req;
    hz.dmem_ack     = s.ack;

    e = '0;
    if (!s.rst) begin
      mWait = 0; mDrain = 0; mFrozen = 0; mStall = 0;
    end else begin
      e.stall = CNT_W'(mStall);
      loadUse = s.mr && s.rw && (s.rd != 5'd0) &&
                ((s.rs1u && s.rs1 == s.rd) || (s.rs2u && s.rs2 == s.rd));
      if (s.req && !s.ack) begin
        mWait++;
        if (mWait == MEM_TIMEOUT) begin
          e.mem_timeout = 1'b1;
          mWait = 0;
        end
        mDrain  = 0;
        mFrozen = 1;
      end else begin
        mWait = 0;
        e.pc_en = 1'b1; e.if_id_en = 1'b1; e.id_ex_en = 1'b1; e.ex_mem_en = 1'b1;
        if (mFrozen) begin
          mFrozen = 0;
        end else if (mDrain > 0) begin
          e.if_id_flush = 1'b1; e.id_ex_flush = 1'b1;
          mDrain--;
        end else if (s.trap) begin
          e.redirect_trap = 1'b1;
          e.if_id_flush = 1'b1; e.id_ex_flush = 1'b1;
          mDrain = TRAP_DRAIN - 1;
        end else if (s.br) begin
          e.if_id_flush = 1'b1; e.id_ex_flush = 1'b1;
        end else if (loadUse) begin
          e.pc_en = 1'b0; e.if_id_en = 1'b0; e.id_ex_flush = 1'b1;
        end
      end
      if (!e.pc_en && mStall < STALL_MAX) mStall++;
    end
    sbq.push_back(e);
  endtask

  task automatic checkOutput(input obs_t exp);
    obs_t act;
    act.pc_en         = hz.PC_EN;
    act.if_id_en      = hz.IF_ID_EN;
    act.if_id_flush   = hz.IF_ID_flush;
    act.id_ex_en      = hz.ID_EX_EN;
    act.id_ex_flush   = hz.ID_EX_flush;
    act.ex_mem_en     = hz.EX_MEM_EN;
    act.redirect_trap = hz.redirect_trap;
    act.mem_timeout   = hz.mem_timeout;
    act.stall         = hz.stall_cycles;
    nChecks++;
    if (act !== exp) begin
      nBad++;
      $display("[TB] FAIL ctrl#%0d got pc/ifen/iffl/idexen/idexfl/exmem/redir/tmo=%b%b%b%b%b%b%b%b stall=%0d want %b%b%b%b%b%b%b%b stall=%0d",
               stepNo, act.pc_en, act.if_id_en, act.if_id_flush, act.id_ex_en,
               act.id_ex_flush, act.ex_mem_en, act.redirect_trap, act.mem_timeout, act.stall,
               exp.pc_en, exp.if_id_en, exp.if_id_flush, exp.id_ex_en,
               exp.id_ex_flush, exp.ex_mem_en, exp.redirect_trap, exp.mem_timeout, exp.stall);
    end
  endtask

  // Monitor: one observation per cycle, sampled mid-cycle away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        checkOutput(sbq.pop_front());
        stepNo++;
      end
    end
  end

  initial begin
    stim_t s;
    stim_t lu;

    hz.rs1_ID = '0; hz.rs2_ID = '0; hz.rs1_used = 1'b0; hz.rs2_used = 1'b0;
    hz.rd_EX = '0; hz.RegWrite_EX = 1'b0; hz.mem_r_EX = 1'b0;
    hz.branch_taken = 1'b0; hz.trap_EX = 1'b0; hz.dmem_req = 1'b0; hz.dmem_ack = 1'b0;

    s = idle(); s.rst = 1'b0;
    repeat (3) applyStimulus(s);
    applyStimulus(idle());

    lu = idle(); lu.rd = 5'd5; lu.mr = 1'b1; lu.rw = 1'b1; lu.rs2 = 5'd5; lu.rs2u = 1'b1;
    applyStimulus(lu);
    applyStimulus(idle());

    s = idle(); s.rd = 5'd0; s.mr = 1'b1; s.rw = 1'b1; s.rs1 = 5'd0; s.rs1u = 1'b1;
    applyStimulus(s);
    s = idle(); s.rd = 5'd7; s.mr = 1'b1; s.rw = 1'b1; s.rs1 = 5'd7; s.rs1u = 1'b0;
    applyStimulus(s);

    s = idle(); s.req = 1'b1;
    repeat (4) applyStimulus(s);
    s.ack = 1'b1;
    applyStimulus(s);
    applyStimulus(idle());

    s = idle(); s.req = 1'b1; s.trap = 1'b1; s.br = 1'b1;
    repeat (7) applyStimulus(s);
    s.ack = 1'b1;
    applyStimulus(s);

    s = idle(); s.trap = 1'b1;
    applyStimulus(s);
    applyStimulus(idle());
    applyStimulus(idle());
    repeat (4) applyStimulus(s);
    applyStimulus(idle());

    s = lu; s.br = 1'b1;
    applyStimulus(s);
    applyStimulus(idle());

    s = idle(); s.trap = 1'b1;
    applyStimulus(s);
    s = idle(); s.rst = 1'b0;
    applyStimulus(s);
    applyStimulus(idle());
    s = idle(); s.req = 1'b1;
    repeat (2) applyStimulus(s);
    s = idle(); s.rst = 1'b0; s.req = 1'b1;
    applyStimulus(s);
    applyStimulus(idle());

    s = idle(); s.req = 1'b1;
    repeat (270) applyStimulus(s);
    s = idle(); s.rst = 1'b0;
    applyStimulus(s);

    for (int i = 0; i < 1500; i++) begin
      s.rst  = ($urandom_range(0, 199) != 0);
      s.rs1  = 5'($urandom_range(0, 3));
      s.rs2  = 5'($urandom_range(0, 3));
      s.rd   = 5'($urandom_range(0, 3));
      s.rs1u = ($urandom_range(0, 3) != 0);
      s.rs2u = ($urandom_range(0, 3) != 0);
      s.rw   = ($urandom_range(0, 3) != 0);
      s.mr   = ($urandom_range(0, 1) == 0);
      s.br   = ($urandom_range(0, 5) == 0);
      s.trap = ($urandom_range(0, 7) == 0);
      s.req  = ($urandom_range(0, 2) == 0);
      s.ack  = ($urandom_range(0, 2) == 0);
      applyStimulus(s);
    end

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      nChecks++;
      nBad++;
      $display("[TB] FAIL drain pending=%0d required=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
